// File: rtl/core_halt_monitor_pkg.sv
// Shared definitions for the core halt monitor: cause codes, FSM states and
// the dump beat count (PC beat plus one beat per architectural register).
package halt_mon_pkg;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_ECALL   = 3'd1;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd2;
  localparam logic [2:0] CAUSE_STUCK   = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned NREGS_DEFAULT = 32;

  // Beats in one dump: the halt PC followed by every register.
  function automatic int unsigned beat_count(input int unsigned nregs);
    return nregs + 1;
  endfunction

endpackage

// File: rtl/core_halt_monitor_if.sv
// Dump stream from the halt monitor to a UART or trace sink.
// Handshake: a beat transfers on a rising clk edge where dump_valid and
// dump_ready are both 1; while dump_valid=1 and dump_ready=0 the master holds
// dump_data and dump_last unchanged, and dump_valid never drops before the
// beat is taken.
interface core_halt_monitor_if #(
  parameter int XLEN = 32
);
  logic            dump_valid;
  logic            dump_ready;
  logic [XLEN-1:0] dump_data;
  logic            dump_last;

  modport master (output dump_valid, output dump_data, output dump_last, input dump_ready);
  modport slave  (input dump_valid, input dump_data, input dump_last, output dump_ready);
endinterface

// File: rtl/core_halt_monitor_watchdog.sv
// Stuck-PC watchdog: counts consecutive enabled cycles in which mem_pc equals
// the remembered PC; stuck is raised once the count reaches WDOG_LIMIT.
// The counter saturates at the limit and never wraps.
module halt_mon_watchdog #(
  parameter int XLEN       = 32,
  parameter int WDOG_LIMIT = 2000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] mem_pc,
  output logic            stuck
);
  localparam int CNT_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_LIMIT);

  logic [XLEN-1:0]  ref_pc_q, ref_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Restart on any PC change, otherwise count up to the limit.
  always_comb begin
    ref_pc_d = ref_pc_q;
    cnt_d    = cnt_q;
    if (en) begin
      if (mem_pc == ref_pc_q) begin
        if (cnt_q != LIMIT) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ref_pc_d = mem_pc;
        cnt_d    = '0;
      end
    end
  end

  // Reference PC and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_pc_q <= '1;
      cnt_q    <= '0;
    end else begin
      ref_pc_q <= ref_pc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stuck = (cnt_q == LIMIT);

endmodule

// File: rtl/core_halt_monitor.sv
// End-of-run controller: detects ECALL/EBREAK/stuck-PC/timeout, halts the
// core, then streams the halt PC and all registers over the dump interface.
// Build option: define HALT_MON_WDOG_EN to include the stuck-PC watchdog;
// without it mem_pc is ignored and cause STUCK is never reported.
module core_halt_monitor
  import halt_mon_pkg::*;
#(
  parameter int          XLEN           = 32,
  parameter int          NREGS          = NREGS_DEFAULT,
  parameter int          WDOG_LIMIT     = 2000000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int          CYC_W          = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ecall_pulse,
  input  logic             ebreak_pulse,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  mem_pc,
  output logic             halt_req,
  output logic [4:0]       rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  core_halt_monitor_if.master dump,
  output logic [2:0]       cause,
  output logic [CYC_W-1:0] cycle_count,
  output logic             done,
  output state_e           state_dbg
);
  localparam int unsigned BEATS = beat_count(NREGS);
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS);

  state_e           state_q, state_d;
  logic [2:0]       cause_q, cause_d;
  logic [XLEN-1:0]  halt_pc_q, halt_pc_d;
  logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [4:0]       rf_raddr_q, rf_raddr_d;
  logic [2:0]       trig_cause;
  logic             stuck;
  logic             beat_fire;

`ifdef HALT_MON_WDOG_EN
  halt_mon_watchdog #(
    .XLEN       (XLEN),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == RUN),
    .mem_pc (mem_pc),
    .stuck  (stuck)
  );
`else
  logic [XLEN-1:0] unused_mem_pc;
  assign unused_mem_pc = mem_pc ^ XLEN'(WDOG_LIMIT);
  assign stuck = 1'b0;
`endif

  assign beat_fire = dump.dump_valid && dump.dump_ready;

  // Highest-priority terminating event this cycle.
  always_comb begin
    trig_cause = CAUSE_NONE;
    if (ecall_pulse)                                   trig_cause = CAUSE_ECALL;
    else if (ebreak_pulse)                             trig_cause = CAUSE_EBREAK;
    else if (stuck)                                    trig_cause = CAUSE_STUCK;
    else if (cycle_count_q == CYC_W'(TIMEOUT_CYCLES))  trig_cause = CAUSE_TIMEOUT;
  end

  // Next-state logic: run until a trigger, drain one cycle, dump, then park.
  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    halt_pc_d     = halt_pc_q;
    cycle_count_d = cycle_count_q;
    idx_d         = idx_q;
    rf_raddr_d    = rf_raddr_q;
    case (state_q)
      RUN: begin
        if (trig_cause != CAUSE_NONE) begin
          cause_d   = trig_cause;
          halt_pc_d = id_pc;
          state_d   = DRAIN;
        end else begin
          cycle_count_d = cycle_count_q + CYC_W'(1);
        end
      end
      DRAIN: begin
        idx_d      = '0;
        rf_raddr_d = '0;
        state_d    = DUMP;
      end
      DUMP: begin
        // Beat 0 is the PC, so the register address only moves after beat 1.
        if (beat_fire) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q != '0) rf_raddr_d = rf_raddr_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cause_q       <= CAUSE_NONE;
      halt_pc_q     <= '0;
      cycle_count_q <= '0;
      idx_q         <= '0;
      rf_raddr_q    <= '0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      halt_pc_q     <= halt_pc_d;
      cycle_count_q <= cycle_count_d;
      idx_q         <= idx_d;
      rf_raddr_q    <= rf_raddr_d;
    end
  end

  assign halt_req        = (state_q != RUN);
  assign dump.dump_valid = (state_q == DUMP);
  assign dump.dump_last  = (state_q == DUMP) && (idx_q == LAST_IDX);
  assign dump.dump_data  = (state_q != DUMP) ? '0 :
                           (idx_q == '0)     ? halt_pc_q : rf_rdata;
  assign done            = (state_q == DONE);
  assign cause           = cause_q;
  assign cycle_count     = cycle_count_q;
  assign rf_raddr        = rf_raddr_q;
  assign state_dbg       = state_q;

endmodule

// File: doc/core_halt_monitor.md
Name: core_halt_monitor

Overview:
- Synthesizable end-of-run controller that sits beside the pipelined core top and consumes its termination signals: ecall/ebreak pulses, the MEM-stage PC and the register file.
- On a terminating event it latches the cause and the ID-stage PC, then asserts a halt to the core.
- It then reads all architectural registers through a spare regfile read port and streams the PC and the registers out over a valid/ready interface to a UART or trace sink.
- It also provides the stuck-PC watchdog and the run-timeout in hardware.

Parameters:
- XLEN, 32, data/PC width.
- NREGS, 32, number of architectural registers dumped.
- WDOG_LIMIT, 2000000, consecutive cycles with an unchanged mem_pc before a STUCK halt.
- TIMEOUT_CYCLES, 50000000, run cycles before a TIMEOUT halt.
- CYC_W, 64, width of the cycle counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- ecall_pulse  in  1  one-cycle ECALL retire indication.
- ebreak_pulse  in  1  one-cycle EBREAK retire indication.
- id_pc  in  XLEN  ID-stage PC; latched as halt_pc.
- mem_pc  in  XLEN  MEM-stage PC; watchdog input.
- halt_req  out  1  freezes core fetch and writeback.
- rf_raddr  out  5  regfile read address.
- rf_rdata  in  XLEN  combinational regfile read data.
- dump_valid  out  1  stream beat valid.
- dump_ready  in  1  stream beat accepted.
- dump_data  out  XLEN  beat payload.
- dump_last  out  1  marks the final beat.
- cause  out  3  0 none, 1 ECALL, 2 EBREAK, 3 STUCK, 4 TIMEOUT.
- cycle_count  out  CYC_W  run cycles since reset.
- done  out  1  dump complete.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state RUN; halt_req, dump_valid, dump_last and done are 0; cause 0; cycle_count 0; rf_raddr 0; dump_data 0; watchdog reference PC 32'hFFFFFFFF; watchdog count 0.
- States: RUN -> DRAIN -> DUMP -> DONE. Reset returns to RUN from any state, including mid-dump; dump_valid is 0 on the cycle after reset is sampled.
- RUN:
  - cycle_count increments every cycle.
  - Watchdog: if mem_pc equals the reference PC, count increments (saturating); otherwise reference <= mem_pc and count <= 0.
  - Triggers are evaluated on registered values: watchdog count == WDOG_LIMIT, cycle_count == TIMEOUT_CYCLES, or either pulse.
  - Priority when events coincide: ECALL > EBREAK > STUCK > TIMEOUT.
  - On a trigger: cause and halt_pc (= id_pc) are latched, halt_req <= 1, cycle_count freezes, next state is DRAIN.
  - Pulses arriving after the trigger are ignored.
- DRAIN:
  - Exactly one cycle, letting the core complete its in-flight writeback under halt_req.
  - Beat index <= 0; next state is DUMP.
- DUMP:
  - NREGS+1 beats. Beat 0 = halt_pc; beat k (1..NREGS) = register x(k-1), read via rf_raddr = k-1 with dump_data = rf_rdata.
  - rf_raddr is registered and updated only on acceptance, so dump_data is stable while dump_valid=1 and dump_ready=0.
  - dump_valid stays 1 until the last beat is accepted; the index advances only on dump_valid & dump_ready.
  - dump_last = 1 on beat NREGS only.
  - Acceptance of the last beat -> DONE.
- DONE: done = 1, halt_req stays 1, dump_valid = 0; the block remains here until reset.
- Width rules: the index counter is clog2(NREGS+1) bits; the watchdog counter is wide enough for WDOG_LIMIT and never wraps; cycle_count never wraps in practice (64 bits).

Optional Feature:
- Macro: HALT_MON_WDOG_EN.
- Defined: the stuck-PC watchdog is present as specified.
- Undefined: the watchdog register, counter and comparator are removed, cause 3 is never produced, and mem_pc is unused. All other behaviour is unchanged.

Decomposition:
- Package halt_mon_pkg holds:
  - the cause encoding constants (CAUSE_NONE/ECALL/EBREAK/STUCK/TIMEOUT);
  - the state enum (RUN, DRAIN, DUMP, DONE);
  - the beat-count constant NREGS+1.
- Sub-module halt_mon_watchdog contains the reference PC, the saturating counter and the stuck flag output. It is instantiated only under HALT_MON_WDOG_EN.

Test Plan:
- ECALL: ecall_pulse at cycle 10 with id_pc=0x00000040, dump_ready held 1 -> cause=1, halt_req high from cycle 11, 33 beats (beat0=0x00000040, then x0..x31 matching a preloaded regfile), dump_last on beat 32, done=1.
- Simultaneous pulses: ecall_pulse and ebreak_pulse in the same cycle -> cause=1; a later ebreak pulse does not change cause.
- Watchdog (WDOG_LIMIT=8): mem_pc held at 0x00000100 from the first cycle after reset release -> trigger at edge 10, cause=3. A single mem_pc change at edge 5 restarts the count.
- Timeout (TIMEOUT_CYCLES=20) with no events -> cause=4; cycle_count frozen at 20.
- Backpressure: dump_ready toggled 1,0,0,1 -> dump_data and rf_raddr constant while stalled; no beat is lost or duplicated; exactly 33 handshakes occur.
- Reset mid-DUMP after beat 5 -> state RUN, dump_valid=0, cause=0, halt_req=0; a subsequent ebreak produces a full 33-beat dump with cause=2.
